// File: rtl/sti_pkg.sv
// Shared definitions for the STI serializer: length codes, their bit counts, FSM states.
// Pure declarations, no logic of its own.
// Imported by the frame builder and the serializer top.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } sti_state_e;

  // Number of serial bits carried by a frame of the given length code.
  function automatic logic [5:0] len_bits(input logic [1:0] code);
    case (code)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/sti_frame_builder.sv
// Builds the 32-bit frame image from one 16-bit word and the length/fill/byte-select controls.
// Purely combinational, zero latency.
// No flow control; the serializer samples the output only when it accepts a load.
module sti_frame_builder
  import sti_pkg::*;
(
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_low,
  output logic [31:0] frame
);

  // Place the payload inside the frame; unused bits are always zero.
  always_comb begin
    frame = '0;
    case (pi_length)
      LEN_8:   frame[7:0]  = pi_low ? pi_data[15:8] : pi_data[7:0];
      LEN_16:  frame[15:0] = pi_data;
      LEN_24:  frame[23:0] = pi_fill ? {pi_data, 8'h00} : {8'h00, pi_data};
      default: frame       = pi_fill ? {pi_data, 16'h0000} : {16'h0000, pi_data};
    endcase
  end

endmodule

// File: rtl/sti_serializer.sv
// Parallel-to-serial transmitter: one 16-bit word per load becomes an 8/16/24/32-bit serial frame.
// Latency 1: first bit appears the cycle after the load edge; one idle cycle separates frames.
// Loads are ignored while busy or finished; with STI_BACKPRESSURE_EN, so_ready=0 stalls the shifter.
module sti_serializer
  import sti_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
`ifdef STI_BACKPRESSURE_EN
  input  logic              so_ready,
`endif
  output logic              so_data,
  output logic              so_valid,
  output logic              busy,
  output logic              sto_done
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_FINISH = FINISH;

  logic [1:0]       state_q;
  logic [31:0]      sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             msb_q;
  logic             end_q;

  logic [31:0]      frame;
  logic [5:0]       len;
  logic [31:0]      aligned;
  logic [31:0]      sh_nxt;
  logic             xfer;

  sti_frame_builder u_frame_builder (
    .pi_data   (pi_data),
    .pi_length (pi_length),
    .pi_fill   (pi_fill),
    .pi_low    (pi_low),
    .frame     (frame)
  );

  // The shift register always presents the current bit at [31] (MSB-first) or [0] (LSB-first),
  // so an MSB-first frame is left-justified at capture and LSB-first frames stay right-justified.
  assign len     = len_bits(pi_length);
  assign aligned = pi_msb ? (frame << (6'd32 - len)) : frame;
  assign sh_nxt  = msb_q ? {sh_q[30:0], 1'b0} : {1'b0, sh_q[31:1]};

`ifdef STI_BACKPRESSURE_EN
  assign xfer = so_ready;
`else
  assign xfer = 1'b1;
`endif

  // Capture on load, shift one bit per transfer, and park in FINISH after the end-of-stream word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      msb_q    <= 1'b0;
      end_q    <= 1'b0;
      so_data  <= 1'b0;
      so_valid <= 1'b0;
      busy     <= 1'b0;
      sto_done <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            sh_q     <= aligned;
            cnt_q    <= CNT_W'(len - 6'd1);
            msb_q    <= pi_msb;
            end_q    <= pi_end;
            so_data  <= pi_msb ? aligned[31] : aligned[0];
            so_valid <= 1'b1;
            busy     <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (xfer) begin
            if (cnt_q == '0) begin
              so_data  <= 1'b0;
              so_valid <= 1'b0;
              busy     <= 1'b0;
              if (end_q) begin
                sto_done <= 1'b1;
                state_q  <= S_FINISH;
              end else begin
                state_q  <= S_IDLE;
              end
            end else begin
              cnt_q   <= cnt_q - CNT_W'(1);
              sh_q    <= sh_nxt;
              so_data <= msb_q ? sh_nxt[31] : sh_nxt[0];
            end
          end
        end
        S_FINISH: begin
          sto_done <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_serializer.sv
// Directed bench for sti_serializer with a scoreboard of expected serial bits.
// Stimulus pushes the expected bit sequence; a negedge monitor pops and compares each valid bit.
// Frame length, idle gap, ignored loads, end-of-stream and mid-frame reset are checked explicitly.
module tb_sti_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] pi_data = '0;
  logic [1:0]  pi_length = '0;
  logic        pi_fill = 1'b0;
  logic        pi_msb = 1'b0;
  logic        pi_low = 1'b0;
  logic        pi_end = 1'b0;
  logic        so_ready = 1'b1;
  logic        so_data;
  logic        so_valid;
  logic        busy;
  logic        sto_done;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  sti_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .pi_data   (pi_data),
    .pi_length (pi_length),
    .pi_fill   (pi_fill),
    .pi_msb    (pi_msb),
    .pi_low    (pi_low),
    .pi_end    (pi_end),
`ifdef STI_BACKPRESSURE_EN
    .so_ready  (so_ready),
`endif
    .so_data   (so_data),
    .so_valid  (so_valid),
    .busy      (busy),
    .sto_done  (sto_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every valid bit must match the head of the queue; idle data must be 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (so_valid === 1'b1) begin
        vectors++;
        assert (exp_q.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_bit observed=%0b expected=no_valid", so_data);
        end
        if (exp_q.size() > 0) begin
          logic e;
          e = exp_q.pop_front();
          vectors++;
          assert (so_data === e) else begin
            miscompares++;
            $error("FAIL serial_bit observed=%0b expected=%0b", so_data, e);
          end
        end
      end else begin
        vectors++;
        assert (so_data === 1'b0) else begin
          miscompares++;
          $error("FAIL idle_data observed=%0b expected=0", so_data);
        end
      end
    end
  end

  // seq[nbits-1] is the first bit expected on the wire. A load with different controls is
  // pulsed while bit number inj is showing (inj=0 disables it).
  task automatic send(input string tag, input logic [15:0] d, input logic [1:0] lc,
                      input logic fill, input logic msb, input logic low, input logic e,
                      input logic [31:0] seq, input int nbits, input int inj);
    int cnt;
    for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(seq[i]);
    pi_data = d; pi_length = lc; pi_fill = fill; pi_msb = msb; pi_low = low; pi_end = e;
    load = 1'b1;
    tick();
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      check({tag, "_valid_while_busy"}, {31'd0, so_valid}, 32'd1);
      if (cnt == inj) begin
        load = 1'b1; pi_data = 16'hFFFF; pi_msb = ~msb; pi_length = 2'b00; pi_end = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    check({tag, "_busy_cycles"}, cnt, nbits);
    check({tag, "_valid_after"}, {31'd0, so_valid}, 32'd0);
    check({tag, "_bits_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_so_valid", {31'd0, so_valid}, 32'd0);
    check("rst_so_data", {31'd0, so_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sto_done", {31'd0, sto_done}, 32'd0);
    rst = 1'b0;
    tick();

    // 8-bit low byte MSB-first: 0,1,0,1,1,0,1,0
    send("t1", 16'hA55A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_005A, 8, 0);
    // 8-bit high byte LSB-first: seven zeros then 1
    send("t2", 16'h8001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 8, 0);
    // 24-bit fill high: 16 ones then 8 zeros; fill low: 8 zeros then 16 ones
    send("t3a", 16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00FF_FF00, 24, 0);
    send("t3b", 16'hFFFF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 24, 0);
    // 32-bit LSB-first: 1 then 31 zeros, with a stray load during bit 5
    send("t4", 16'h0001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32, 5);
    check("t4_still_not_done", {31'd0, sto_done}, 32'd0);

    // Two-word stream: second word ends it, one idle cycle between frames
    send("t5a", 16'hC3A5, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_C3A5, 16, 0);
    check("t5_gap_busy", {31'd0, busy}, 32'd0);
    send("t5b", 16'h00F0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00F0, 8, 0);
    check("t5_sto_done", {31'd0, sto_done}, 32'd1);
    pi_data = 16'h5555; pi_length = 2'b01; pi_end = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_done_hold", {31'd0, sto_done}, 32'd1);
    check("t5_done_busy", {31'd0, busy}, 32'd0);

    // Mid-frame reset after the 3rd bit of 16'hABCD (MSB-first: 1,0,1)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t6_done_cleared", {31'd0, sto_done}, 32'd0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    pi_data = 16'hABCD; pi_length = 2'b01; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0; pi_end = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, so_valid}, 32'd0);
    check("t6_rst_data", {31'd0, so_data}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_bits_seen", exp_q.size(), 0);
    tick();
    rst = 1'b0;
    tick();
    send("t6_fresh", 16'h1234, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 16, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sti_serializer.md
Name: sti_serializer

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the DAC memory-write stage and drives its so_data/so_valid inputs.
- Accepts one 16-bit word per load pulse.
- Builds an 8/16/24/32-bit frame from that word using the length, fill, byte-select and bit-order controls.
- Shifts the frame out one bit per clock with so_valid high for exactly the frame length.

Parameters:
DATA_W, 16, input word width (only 16 supported)
CNT_W, 5, bit-counter width (covers 0..31)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
load  input  1  one-cycle request to send pi_data; sampled only when busy=0
pi_data  input  16  payload word
pi_length  input  2  frame length: 00=8, 01=16, 10=24, 11=32 bits
pi_fill  input  1  24/32-bit only: 1=data in upper bits, zero-pad low; 0=zero-pad high, data in low bits
pi_msb  input  1  1=MSB of frame sent first; 0=LSB first
pi_low  input  1  8-bit only: 1=send pi_data[15:8]; 0=send pi_data[7:0]
pi_end  input  1  marks the last word of the stream
so_data  output  1  serial bit; 0 whenever so_valid=0
so_valid  output  1  high for each valid serial bit
busy  output  1  high while a frame is being shifted
sto_done  output  1  high from the cycle after the last bit of the pi_end word, until reset

Behaviour:
- Reset: state IDLE; so_data, so_valid, busy and sto_done all 0; frame register and counter cleared. Reset asserted mid-frame aborts the frame immediately; no partial resume.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - load=1 at an edge captures the 32-bit frame, L (length), pi_msb and pi_end.
  - Counter is set to L-1; next state SHIFT.
- Frame build (L = 8/16/24/32):
  - L=8: frame[7:0] = pi_low ? pi_data[15:8] : pi_data[7:0].
  - L=16: frame[15:0] = pi_data.
  - L=24: pi_fill ? {pi_data, 8'h00} : {8'h00, pi_data}.
  - L=32: pi_fill ? {pi_data, 16'h0000} : {16'h0000, pi_data}.
- SHIFT:
  - so_valid=1 and busy=1 for exactly L cycles, starting the cycle after the load edge (latency 1).
  - pi_msb=1: bits go out frame[L-1] down to frame[0]. pi_msb=0: frame[0] up to frame[L-1].
  - so_data is registered; it comes from the frame register, not from live inputs.
  - Counter decrements each cycle. At 0: if captured pi_end=1, go to FINISH; otherwise go to IDLE.
- Back-to-back frames: at least 1 idle cycle (so_valid=0, busy=0) separates consecutive frames.
- load while busy=1 or in FINISH is ignored and does not disturb the in-flight frame.
- Input changes during SHIFT have no effect, because all controls are captured at load.
- FINISH: sto_done=1, so_valid=0, so_data=0; the block stays here until reset.
- Unknown/X pi_length is not supported; the encoding is complete (all four codes are valid).

Optional Feature:
- Macro: STI_BACKPRESSURE_EN.
- Defined:
  - Adds input so_ready (1 bit).
  - In SHIFT, a bit counts as transferred only in a cycle with so_valid=1 and so_ready=1.
  - While so_ready=0, so_data and so_valid hold and the counter does not change.
  - Transitions out of SHIFT happen only on the transfer of the last bit.
- Undefined: no so_ready port; every SHIFT cycle transfers one bit.

Decomposition:
- Package sti_pkg holds:
  - Length codes LEN_8=2'b00, LEN_16=2'b01, LEN_24=2'b10, LEN_32=2'b11.
  - Function len_bits(code) returning 8/16/24/32.
  - State enum {IDLE, SHIFT, FINISH}.
- Sub-module sti_frame_builder: purely combinational. Inputs pi_data, pi_length, pi_fill, pi_low; output 32-bit frame. The top level registers its output at load.

Test Plan:
1. 8-bit, pi_data=16'hA55A, pi_low=0, pi_msb=1, load at cycle T -> cycles T+1..T+8 carry 0,1,0,1,1,0,1,0 with so_valid=1; so_valid=0 at T+9.
2. 8-bit, pi_data=16'h8001, pi_low=1, pi_msb=0 -> 0,0,0,0,0,0,0,1; busy high for exactly 8 cycles.
3. 24-bit, pi_data=16'hFFFF, pi_msb=1: pi_fill=1 -> 16 ones then 8 zeros; pi_fill=0 -> 8 zeros then 16 ones.
4. 32-bit, pi_data=16'h0001, pi_fill=0, pi_msb=0 -> 1 then 31 zeros, 32 valid cycles. Pulse load with 16'hFFFF at bit 5 -> ignored, stream unchanged.
5. Two words, second with pi_end=1 -> 1 idle gap between frames; sto_done=1 the cycle after the last bit; a later load produces no so_valid.
6. Assert rst after the 3rd bit of a 16-bit frame -> so_valid, so_data and busy go to 0 immediately. A fresh load of 16'h1234 (msb-first) after reset -> 0001001000110100.
